// File: rtl/count_stream_monitor_if.sv
// rtl/count_stream_monitor_if.sv - counter value input and monitor result signals
interface count_stream_monitor_if;
    logic [3:0] count_in;
    logic [3:0] stable_count;
    logic       value_valid;
    logic       wrap_pulse;
    logic [3:0] wraps_tens;
    logic [3:0] wraps_ones;
    logic       step_err;
    logic [3:0] err_count;
    logic       err_flag;

    // Producer of the raw count, consumer of the results
    modport master (
        output count_in,
        input  stable_count, value_valid, wrap_pulse, wraps_tens, wraps_ones,
               step_err, err_count, err_flag
    );

    // The monitor itself
    modport slave (
        input  count_in,
        output stable_count, value_valid, wrap_pulse, wraps_tens, wraps_ones,
               step_err, err_count, err_flag
    );
endinterface

// File: rtl/count_stream_monitor.sv
// rtl/count_stream_monitor.sv - synchronise, deglitch and validate a ripple down-counter
module count_stream_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    count_stream_monitor_if.slave bus
);

    localparam logic [3:0] RUN_MAX   = 4'(STABLE_CYCLES);
    localparam logic [3:0] ACCEPT_AT = 4'(STABLE_CYCLES - 1);

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_val;
    logic [3:0] candidate;
    logic [3:0] run_cnt;
    logic       accept;

    logic       primed;
    logic [3:0] stable_q;
    logic       value_valid_q;
    logic       wrap_q;
    logic       step_err_q;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic [3:0] err_count_q;
    logic       err_flag_q;

    assign sync_val = sync_q[SYNC_STAGES-1];

    // A value is taken once it has matched the previous sample for the full window;
    // the run counter then sits at RUN_MAX so a held level is accepted only once.
    assign accept = (run_cnt == ACCEPT_AT) && (sync_val == candidate);

    // Per-bit flop chain bringing the asynchronous count into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.count_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Stability filter: count consecutive cycles the synchronised value holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            candidate <= '0;
            run_cnt   <= '0;
        end else begin
            candidate <= sync_val;
            if (sync_val != candidate) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

    // Acceptance: classify the step, raise one-cycle pulses and update tallies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed        <= 1'b0;
            stable_q      <= '0;
            value_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
            step_err_q    <= 1'b0;
            tens_q        <= '0;
            ones_q        <= '0;
            err_count_q   <= '0;
            err_flag_q    <= 1'b0;
        end else begin
            value_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
            step_err_q    <= 1'b0;
            if (accept) begin
                if (!primed) begin
                    // First value after reset has no predecessor to check against
                    stable_q      <= candidate;
                    value_valid_q <= 1'b1;
                    primed        <= 1'b1;
                end else if (candidate != stable_q) begin
                    stable_q      <= candidate;
                    value_valid_q <= 1'b1;
                    if (candidate == stable_q - 4'd1) begin
                        if (stable_q == 4'd0) begin
                            wrap_q <= 1'b1;
                            if (ones_q == 4'd9) begin
                                ones_q <= 4'd0;
                                tens_q <= (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                            end else begin
                                ones_q <= ones_q + 4'd1;
                            end
                        end
                    end else begin
                        step_err_q <= 1'b1;
                        err_flag_q <= 1'b1;
                        if (err_count_q != 4'd15) begin
                            err_count_q <= err_count_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign bus.stable_count = stable_q;
    assign bus.value_valid  = value_valid_q;
    assign bus.wrap_pulse   = wrap_q;
    assign bus.wraps_tens   = tens_q;
    assign bus.wraps_ones   = ones_q;
    assign bus.step_err     = step_err_q;
    assign bus.err_count    = err_count_q;
    assign bus.err_flag     = err_flag_q;

endmodule
